// File: rtl/ram_row_reader_if.sv
// Row output stream of ram_row_reader.
// Valid/ready handshake carrying one RAM row and its address.
interface ram_row_reader_if #(
  parameter int AWIDTH = 10,
  parameter int RW     = 128
);
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_data;
  logic [AWIDTH-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );
endinterface

// File: rtl/ram_row_reader.sv
// Burst reader: streams num_rows consecutive RAM rows from base_addr
// through a 2-entry skid FIFO onto a valid/ready output.
module ram_row_reader #(
  parameter int AWIDTH      = 10,
  parameter int DESIGN_SIZE = 16,
  parameter int DWIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             base_addr,
  input  logic [AWIDTH:0]               num_rows,
  output logic                          busy,
  output logic                          done,
  output logic [AWIDTH-1:0]             ram_addr,
  output logic [DESIGN_SIZE-1:0]        ram_we,
  output logic [DESIGN_SIZE*DWIDTH-1:0] ram_d,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q,
  ram_row_reader_if.master              ob
);

  localparam int RW = DESIGN_SIZE * DWIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [AWIDTH-1:0] nxt_addr;
  logic [AWIDTH-1:0] last_addr;
  logic [AWIDTH:0]   rem;
  logic              infl;

  logic [RW-1:0]     fd [2];
  logic [AWIDTH-1:0] fa [2];
  logic              wp;
  logic              rp;
  logic [1:0]        cnt;

  logic              pop;
  logic              issue;
  logic [1:0]        occ;

  // Occupancy counts the slot freed by a pop this cycle, so a
  // continuously ready consumer sees one row per cycle.
  assign pop   = (cnt != 2'd0) && ob.out_ready;
  assign occ   = cnt + {1'b0, infl} - {1'b0, pop};
  assign issue = (state == S_READ) && (occ < 2'd2);

  assign ram_addr = issue ? nxt_addr : last_addr;
  assign ram_we   = '0;
  assign ram_d    = '0;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DRAIN) && !infl && (cnt == 2'd0);

  assign ob.out_valid = (cnt != 2'd0);
  assign ob.out_data  = fd[rp];
  assign ob.out_addr  = fa[rp];

  // Burst control: capture request, issue reads, retire the burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      nxt_addr  <= '0;
      last_addr <= '0;
      rem       <= '0;
      infl      <= 1'b0;
    end else begin
      infl <= issue;
      if (issue) begin
        last_addr <= nxt_addr;
        nxt_addr  <= nxt_addr + 1'b1;
        rem       <= rem - 1'b1;
      end
      unique case (1'b1)
        (state == S_IDLE): begin
          if (start) begin
            nxt_addr <= base_addr;
            rem      <= num_rows;
            if (num_rows == '0) state <= S_DRAIN;
            else                state <= S_READ;
          end
        end
        (state == S_READ): begin
          if (issue && rem == 1) state <= S_DRAIN;
        end
        (state == S_DRAIN): begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row FIFO: capture returning RAM data, release on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fd[i] <= '0;
        fa[i] <= '0;
      end
    end else begin
      if (infl) begin
        fd[wp] <= ram_q;
        fa[wp] <= last_addr;
        wp     <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, infl} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_row_reader.sv
// Bench for ram_row_reader: RAM model, random rows, expected-row
// queue built from base/count, directed burst sequence.
module tb_ram_row_reader;

  localparam int AW    = 10;
  localparam int DS    = 16;
  localparam int DW    = 8;
  localparam int RW    = DS * DW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DS-1:0] ram_we;
  logic [RW-1:0] ram_d;
  logic [RW-1:0] ram_q;

  ram_row_reader_if #(.AWIDTH(AW), .RW(RW)) ob ();

  ram_row_reader #(
    .AWIDTH(AW),
    .DESIGN_SIZE(DS),
    .DWIDTH(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .num_rows (num_rows),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_d    (ram_d),
    .ram_q    (ram_q),
    .ob       (ob)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] mem [DEPTH];

  always @(posedge clk) ram_q <= mem[ram_addr];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] b,
                           input int n,
                           input bit rnd,
                           input bit poke);
    logic [AW-1:0] qa[$];
    logic [RW-1:0] qd[$];
    logic [AW-1:0] a;
    logic [AW-1:0] addr0;
    logic [AW-1:0] pa;
    logic [RW-1:0] pd;
    logic          pv;
    logic          pr;
    int            cyc;
    int            dcnt;
    int            stall;
    int            limit;
    for (int i = 0; i < n; i++) begin
      a = AW'(int'(b) + i);
      qa.push_back(a);
      qd.push_back(mem[a]);
    end
    limit = 4 * n + 60;
    @(negedge clk);
    addr0     = ram_addr;
    start     = 1'b1;
    base_addr = b;
    num_rows  = (AW+1)'(n);
    cyc   = 0;
    dcnt  = 0;
    stall = 0;
    pv    = 1'b0;
    pr    = 1'b0;
    pa    = '0;
    pd    = '0;
    while (dcnt == 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 5) begin
        start     = 1'b1;
        base_addr = AW'(100);
        num_rows  = (AW+1)'(3);
      end
      if (!rnd) begin
        ob.out_ready = 1'b1;
      end else begin
        if (cyc == 6) stall = 5;
        if (stall > 0) begin
          ob.out_ready = 1'b0;
          stall--;
        end else begin
          ob.out_ready = 1'($urandom_range(0, 1));
        end
      end
      #1;
      if (cyc == 1) begin
        if (n > 0) chk("first_addr", 128'(ram_addr), 128'(b));
        else       chk("zero_addr_hold", 128'(ram_addr), 128'(addr0));
        chk("busy_run", 128'(busy), 128'(1));
      end
      if (n == 0) chk("zero_no_valid", 128'(ob.out_valid), 128'(0));
      if (n > 0 && cyc == 2)
        chk("latency_early", 128'(ob.out_valid), 128'(0));
      if (n > 0 && cyc == 3)
        chk("latency_first", 128'(ob.out_valid), 128'(1));
      if (!rnd && n > 0 && cyc > 3 && cyc < 3 + n)
        chk("no_bubble", 128'(ob.out_valid), 128'(1));
      if (pv && !pr) begin
        chk("stall_valid", 128'(ob.out_valid), 128'(1));
        chk("stall_data", ob.out_data, pd);
        chk("stall_addr", 128'(ob.out_addr), 128'(pa));
      end
      if (ob.out_valid && ob.out_ready) begin
        if (qa.size() > 0) begin
          chk("row_addr", 128'(ob.out_addr), 128'(qa.pop_front()));
          chk("row_data", ob.out_data, qd.pop_front());
        end else begin
          chk("extra_row", 128'(ob.out_valid), 128'(0));
        end
      end
      if (done) begin
        dcnt++;
        chk("done_rows_left", 128'(qa.size()), 128'(0));
        if (!rnd)
          chk("done_cycle", 128'(cyc), 128'(n == 0 ? 1 : 3 + n));
      end
      pv = ob.out_valid;
      pr = ob.out_ready;
      pd = ob.out_data;
      pa = ob.out_addr;
    end
    start = 1'b0;
    chk("done_seen", 128'(dcnt), 128'(1));
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle_busy", 128'(busy), 128'(0));
      chk("idle_done", 128'(done), 128'(0));
      chk("idle_valid", 128'(ob.out_valid), 128'(0));
    end
  endtask

  task automatic reset_abort();
    int got;
    int cyc;
    @(negedge clk);
    start        = 1'b1;
    base_addr    = '0;
    num_rows     = (AW+1)'(16);
    ob.out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 20) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      #1;
      if (ob.out_valid && ob.out_ready) begin
        chk("pre_reset_addr", 128'(ob.out_addr), 128'(got));
        chk("pre_reset_data", ob.out_data, mem[got]);
        got++;
      end
    end
    chk("pre_reset_rows", 128'(got), 128'(3));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_valid", 128'(ob.out_valid), 128'(0));
    chk("abort_ram_addr", 128'(ram_addr), 128'(0));
    chk("abort_data", ob.out_data, 128'(0));
    chk("abort_addr", 128'(ob.out_addr), 128'(0));
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_stays_empty", 128'(ob.out_valid), 128'(0));
      chk("abort_no_done", 128'(done), 128'(0));
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    num_rows     = '0;
    ob.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(ob.out_valid), 128'(0));
    chk("rst_ram_addr", 128'(ram_addr), 128'(0));
    chk("rst_data", ob.out_data, 128'(0));
    chk("rst_addr", 128'(ob.out_addr), 128'(0));
    chk("rst_we", 128'(ram_we), 128'(0));
    chk("rst_d", ram_d, 128'(0));
    reset = 1'b0;

    run_burst(AW'(0), 16, 1'b0, 1'b0);
    run_burst(AW'(1020), 8, 1'b0, 1'b0);
    run_burst(AW'($urandom), 16, 1'b1, 1'b0);
    run_burst(AW'(37), 0, 1'b0, 1'b0);
    run_burst(AW'(200), 16, 1'b0, 1'b1);
    run_burst(AW'(500), 1, 1'b0, 1'b0);
    reset_abort();
    run_burst(AW'(5), 2, 1'b0, 1'b0);
    repeat (3)
      run_burst(AW'($urandom), $urandom_range(1, 24), 1'b1, 1'b0);
    run_burst(AW'(3), 1024, 1'b0, 1'b0);
    chk("we_const", 128'(ram_we), 128'(0));
    chk("d_const", ram_d, 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_row_reader.md
RAM_ROW_READER -- requirements
Module: ram_row_reader

Interface
REQ-001 Parameter AWIDTH, default 10, RAM address width.
REQ-002 Parameter DESIGN_SIZE, default 16, byte lanes per RAM row.
REQ-003 Parameter DWIDTH, default 8, bits per lane; row width RW = DESIGN_SIZE*DWIDTH.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base_addr  input  AWIDTH  first row address, captured on accepted start.
REQ-008 num_rows  input  AWIDTH+1  row count, captured on accepted start; 0 to 2^AWIDTH.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse at burst completion.
REQ-011 ram_addr  output  AWIDTH  read address to RAM port.
REQ-012 ram_we  output  DESIGN_SIZE  lane write enables; constant 0.
REQ-013 ram_d  output  RW  write data; constant 0.
REQ-014 ram_q  input  RW  RAM read data, valid exactly one cycle after ram_addr is presented.
REQ-015 out_valid  output  1  out_data/out_addr hold a valid row.
REQ-016 out_ready  input  1  downstream accepts the row when high with out_valid.
REQ-017 out_data  output  RW  row data, lane j at bits [j*DWIDTH +: DWIDTH].
REQ-018 out_addr  output  AWIDTH  RAM address the current out_data was read from.

Function
REQ-019 States IDLE, READ, DRAIN; IDLE->READ on start with num_rows>0; IDLE->DRAIN-complete path on start with num_rows=0 (see REQ-027).
REQ-020 READ: issue one read per cycle (ram_addr = next address, issue flag high) only when in-flight reads + buffered rows < 2.
REQ-021 Address increments by 1 per issued read, wrapping modulo 2^AWIDTH (1023 -> 0 at default).
REQ-022 READ->DRAIN in the cycle the last of num_rows reads is issued.
REQ-023 Each issued read's ram_q, sampled one cycle later, is pushed with its address into a 2-entry FIFO; never overflows by REQ-020.
REQ-024 out_valid = FIFO non-empty; out_data/out_addr = FIFO head; pop on out_valid & out_ready.
REQ-025 out_data/out_addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Rows delivered strictly in address order, each exactly once; no bubbles when out_ready held high (one row per cycle after first-row latency).
REQ-027 DRAIN->IDLE when no reads in flight and FIFO empty; done pulses in the cycle after that final pop; num_rows=0 start: done pulses the next cycle, no reads issued, busy high that one cycle.
REQ-028 First-row latency: start at cycle T -> ram_addr=base_addr at T+1 -> out_valid at T+3.
REQ-029 start while busy SHALL be ignored; captured parameters unaffected.
REQ-030 When no read is issued, ram_addr holds its last value.

Reset
REQ-031 reset SHALL force IDLE, busy=0, done=0, out_valid=0, FIFO empty, in-flight count 0, ram_addr=0, out_data=0, out_addr=0.
REQ-032 reset mid-burst SHALL abort immediately; data returning from a read issued before reset SHALL be discarded; no done pulse.
REQ-033 reset has priority over start in the same cycle.

Verification
REQ-034 Preload rows 0..15 with random data, start base=0 num=16, out_ready=1 -> 16 rows in order, out_addr 0..15, one per cycle from T+3, done once.
REQ-035 base=1020, num=8 -> out_addr 1020,1021,1022,1023,0,1,2,3 with matching data.
REQ-036 num=16, out_ready toggled randomly and held low 5 cycles -> data stable while stalled, no loss/duplication, never more than 2 rows outstanding.
REQ-037 start with num=0 -> no RAM address change, done pulse next cycle, out_valid never high.
REQ-038 reset asserted after 3 rows of a 16-row burst -> all outputs at reset values next cycle; new burst base=5 num=2 then returns rows 5,6 only.
REQ-039 start pulsed again during busy burst (base=100) -> ignored; original burst completes unchanged.
